// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: instruction fetch front end with a small instruction queue.
// Issues one memory read at a time from the PC register value and steers that
// register through next_pc/pc_freeze. Responses are queued towards IF/ID.
// A branch redirect flushes the queue and drops any response still in flight.
// Optional build macro IF_BYPASS_EN: a response arriving while the queue is
// empty and IF/ID is not frozen goes straight to out_* in the same cycle and
// is not stored.
module if_fetch_buffer #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pc_freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        freeze,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             discard_reg, discard_next;
    logic [31:0]      fetch_addr_reg;
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc4_mem   [DEPTH];

    logic        accept;
    logic        resp_live;
    logic        bypass;
    logic        push;
    logic        pop;
    logic [31:0] resp_pc4;

    // A request is withdrawn while a redirect is in progress so that no
    // stale-address fetch can be accepted in the redirect cycle.
    assign imem_req  = (state_reg == REQ) && !branch_taken;
    assign imem_addr = imem_req ? pc : 32'h0;
    assign accept    = imem_req && imem_ready;

    // A response is only kept when it belongs to a live (non-discarded)
    // request and no redirect flushes it in the same cycle.
    assign resp_live = (state_reg == WAIT) && imem_rvalid && !discard_reg && !branch_taken;
    assign resp_pc4  = fetch_addr_reg + 32'd4;

`ifdef IF_BYPASS_EN
    assign bypass = resp_live && (count_reg == '0) && !freeze;
`else
    assign bypass = 1'b0;
`endif

    assign push = resp_live && !bypass;
    assign pop  = (count_reg != '0) && !freeze && !branch_taken;

    // Occupancy after this edge; a redirect empties the queue outright.
    always_comb begin
        count_next = count_reg;
        if (branch_taken) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Fetch FSM: next state and discard bookkeeping.
    always_comb begin
        state_next   = state_reg;
        discard_next = discard_reg;
        if (discard_reg && imem_rvalid) begin
            discard_next = 1'b0;
        end
        case (state_reg)
            IDLE: begin
                if (!branch_taken && !discard_reg && (count_reg < DEPTH_CNT)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (branch_taken) begin
                    state_next = IDLE;
                end else if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (branch_taken) begin
                    state_next = IDLE;
                    if (!imem_rvalid) begin
                        discard_next = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_next = (count_next < DEPTH_CNT) ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // PC register steering: advance on acceptance, jump on redirect, hold otherwise.
    always_comb begin
        next_pc   = pc;
        pc_freeze = 1'b1;
        if (reset) begin
            next_pc = RESET_PC;
        end else if (branch_taken) begin
            next_pc   = branch_addr;
            pc_freeze = 1'b0;
        end else if (accept) begin
            next_pc   = pc + 32'd4;
            pc_freeze = 1'b0;
        end
    end

    // Control state, queue pointers and the address of the outstanding fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            discard_reg    <= 1'b0;
            count_reg      <= '0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            fetch_addr_reg <= 32'h0;
        end else begin
            state_reg   <= state_next;
            discard_reg <= discard_next;
            count_reg   <= count_next;
            if (branch_taken) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
            end
            if (accept) begin
                fetch_addr_reg <= pc;
            end
        end
    end

    // Queue storage; contents need no reset because occupancy gates the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= imem_rdata;
            pc4_mem[wr_ptr_reg]   <= resp_pc4;
        end
    end

    // Head of queue (or bypassed response) towards IF/ID; zero when nothing valid.
    always_comb begin
        out_valid = 1'b0;
        out_instr = 32'h0;
        out_pc4   = 32'h0;
        if (count_reg != '0) begin
            out_valid = 1'b1;
            out_instr = instr_mem[rd_ptr_reg];
            out_pc4   = pc4_mem[rd_ptr_reg];
        end else if (bypass) begin
            out_valid = 1'b1;
            out_instr = imem_rdata;
            out_pc4   = resp_pc4;
        end
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb_if_fetch_buffer: randomized bench for if_fetch_buffer (default build).
// Contains a PC register, a one-request memory with random latency and a
// queue-based reference model of the instruction stream seen by IF/ID.
module tb_if_fetch_buffer;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        freeze;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pops = 0;

    // reference model state
    entry_t      q[$];
    bit          mem_pend;
    bit          mem_drop;
    int          mem_delay;
    logic [31:0] mem_addr;
    logic [31:0] exp_addr;
    logic [31:0] model_fetch;
    int          frz_left;
    bit          chk_target;

    always #5 clk = ~clk;

    if_fetch_buffer #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .next_pc     (next_pc),
        .pc_freeze   (pc_freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .freeze      (freeze),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc4     (out_pc4)
    );

    // PC register driven by the fetch unit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= RESET_PC;
        else if (!pc_freeze) pc <= next_pc;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        mem_pend    = 1'b0;
        mem_drop    = 1'b0;
        mem_delay   = 0;
        mem_addr    = 32'h0;
        exp_addr    = 32'h0;
        model_fetch = RESET_PC;
        frz_left    = 0;
        chk_target  = 1'b0;
    endtask

    // Assert reset mid-cycle, check immediate outputs, release, check first request.
    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        reset        = 1'b1;
        branch_taken = 1'b0;
        imem_rvalid  = 1'b0;
        imem_ready   = 1'b0;
        freeze       = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'h0);
        check_val("rst_out_instr", out_instr, 32'h0);
        check_val("rst_out_pc4", out_pc4, 32'h0);
        check_val("rst_imem_req", 32'(imem_req), 32'h0);
        check_val("rst_imem_addr", imem_addr, 32'h0);
        check_val("rst_pc_freeze", 32'(pc_freeze), 32'h1);
        check_val("rst_next_pc", next_pc, RESET_PC);
        model_clear();
        repeat (cycles) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("first_req", 32'(imem_req), 32'h1);
        check_val("first_addr", imem_addr, RESET_PC);
        $display("reset released, fetch restarts at %h", RESET_PC);
    endtask

    // mode 0: random; mode 1: frozen consumer, memory ready, no branch;
    // mode 2: random, but redirect to 0x100 while a response is still pending.
    task automatic do_cycle(input int mode);
        entry_t      e;
        bit          acc;
        bit          keep;
        logic [31:0] ba;
        @(posedge clk);
        #1;
        imem_rvalid = mem_pend && (mem_delay == 0);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom();
        imem_ready  = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (mode == 1) begin
            freeze = 1'b1;
        end else if (frz_left > 0) begin
            freeze = 1'b1;
            frz_left--;
        end else begin
            freeze = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) frz_left = 5;
        end
        case ($urandom_range(0, 3))
            0:       ba = 32'h0000_0100;
            1:       ba = 32'hFFFF_FFF8;
            default: ba = $urandom() & 32'hFFFF_FFFC;
        endcase
        if (mode == 2) begin
            branch_taken = mem_pend && !imem_rvalid;
            ba           = 32'h0000_0100;
        end else if (mode == 1) begin
            branch_taken = 1'b0;
        end else begin
            branch_taken = ($urandom_range(0, 11) == 0);
        end
        branch_addr = ba;

        @(negedge clk);
        acc = imem_req && imem_ready;
        check_val("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_val("out_instr", out_instr, q[0].instr);
            check_val("out_pc4", out_pc4, q[0].pc4);
        end
        if (branch_taken) begin
            check_val("br_next_pc", next_pc, branch_addr);
            check_val("br_pc_freeze", 32'(pc_freeze), 32'h0);
            check_val("br_no_accept", 32'(acc), 32'h0);
        end else if (acc) begin
            check_val("acc_addr", imem_addr, model_fetch);
            check_val("acc_next_pc", next_pc, model_fetch + 32'd4);
            check_val("acc_pc_freeze", 32'(pc_freeze), 32'h0);
            check_val("acc_one_outstanding", 32'(mem_pend), 32'h0);
            check_val("acc_credit", 32'(q.size() < DEPTH), 32'h1);
        end else begin
            check_val("hold_pc_freeze", 32'(pc_freeze), 32'h1);
        end

        keep = 1'b0;
        if (imem_rvalid) begin
            keep     = !mem_drop && !branch_taken;
            mem_pend = 1'b0;
        end
        if ((q.size() != 0) && !freeze && !branch_taken) begin
            if (chk_target) begin
                check_val("redirect_target_pc4", out_pc4, 32'h0000_0104);
                chk_target = 1'b0;
            end
            e = q.pop_front();
            n_pops++;
            $display("issue pc4=%h instr=%h", e.pc4, e.instr);
        end
        if (branch_taken) begin
            q.delete();
            if (mem_pend) mem_drop = 1'b1;
            model_fetch = branch_addr;
            chk_target  = (mode == 2);
            $display("redirect to %h", branch_addr);
        end
        if (keep) begin
            e.instr = mem_word(exp_addr);
            e.pc4   = exp_addr + 32'd4;
            q.push_back(e);
        end
        if (acc) begin
            mem_pend    = 1'b1;
            mem_drop    = 1'b0;
            mem_addr    = imem_addr;
            exp_addr    = model_fetch;
            mem_delay   = $urandom_range(0, 2);
            model_fetch = model_fetch + 32'd4;
        end else if (mem_pend && (mem_delay > 0)) begin
            mem_delay--;
        end
    endtask

    initial begin
        bit hit;
        reset        = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        imem_ready   = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        freeze       = 1'b0;
        model_clear();

        do_reset(2);
        repeat (300) do_cycle(0);

        // consumer stalled: queue must fill and requests must stop
        repeat (16) do_cycle(1);
        check_val("full_no_req", 32'(imem_req), 32'h0);
        check_val("full_out_valid", 32'(out_valid), 32'h1);
        check_val("full_pc_freeze", 32'(pc_freeze), 32'h1);
        repeat (100) do_cycle(0);

        // redirect while a response is outstanding
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            do_cycle(2);
            hit = branch_taken;
        end
        check_val("redirect_in_wait", 32'(hit), 32'h1);
        repeat (100) do_cycle(0);

        // reset while a fetch is outstanding
        for (int i = 0; i < 60 && !mem_pend; i++) do_cycle(0);
        check_val("pending_before_reset", 32'(mem_pend), 32'h1);
        do_reset(2);
        repeat (300) do_cycle(0);

        check_val("progress", 32'(n_pops > 100), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
